mem_bus_arbiter: RTL and testbench

- Shares the single external memory bus between the instruction-fetch port (IC, read-only) and the Memory pipeline stage (DC, read/write).
- Each requester sees a private copy of the standard bus interface: level request, address, size, data, and rw_wait.
- A registered grant FSM passes the owner's request through to the bus. DC has priority, and a starvation counter guarantees IC progress.
- Sits between the fetch unit / Memory stage and the memory or cache controller.

---
 rtl/mem_bus_arbiter_if.sv | 46 ++++
 rtl/mem_bus_arbiter.sv | 117 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle around mem_bus_arbiter: two requester ports (IC, DC) plus the shared memory bus.
// The arbiter uses the slave view; the requesters/memory side uses the master view.
interface mem_bus_arbiter_if;
    logic [31:0] ic_busaddr;
    logic        ic_rd_req;
    logic        ic_rw_wait;
    logic [31:0] ic_rd_data;

    logic [31:0] dc_busaddr;
    logic        dc_rd_req;
    logic        dc_wr_req;
    logic [31:0] dc_wr_data;
    logic [2:0]  dc_data_size;
    logic        dc_rw_wait;
    logic [31:0] dc_rd_data;

    logic [31:0] mem_busaddr;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [31:0] mem_wr_data;
    logic [2:0]  mem_data_size;
    logic        mem_wait;
    logic [31:0] mem_rd_data;

    logic [1:0]  grant;

    modport slave (
        input  ic_busaddr, ic_rd_req,
        output ic_rw_wait, ic_rd_data,
        input  dc_busaddr, dc_rd_req, dc_wr_req, dc_wr_data, dc_data_size,
        output dc_rw_wait, dc_rd_data,
        output mem_busaddr, mem_rd_req, mem_wr_req, mem_wr_data, mem_data_size,
        input  mem_wait, mem_rd_data,
        output grant
    );

    modport master (
        output ic_busaddr, ic_rd_req,
        input  ic_rw_wait, ic_rd_data,
        output dc_busaddr, dc_rd_req, dc_wr_req, dc_wr_data, dc_data_size,
        input  dc_rw_wait, dc_rd_data,
        input  mem_busaddr, mem_rd_req, mem_wr_req, mem_wr_data, mem_data_size,
        output mem_wait, mem_rd_data,
        input  grant
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between instruction fetch (IC) and the Memory stage (DC).
// DC has priority; a saturating starvation counter forces IC in after STARVE_LIMIT DC grants.
module mem_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_bus_arbiter_if.slave   bus
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(15);
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
    localparam logic [2:0]       SIZE_WORD = 3'b100;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        OWN_IC = 2'b01,
        OWN_DC = 2'b10
    } state_e;

    state_e           state_q, state_d, arb;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic [CNT_W-1:0] cnt_inc, cnt_eff;
    logic             ic_req, dc_req, ic_active, dc_active, dc_done, starved;

    // Request decode and the arbitration choice for this cycle
    always_comb begin
        ic_req    = bus.ic_rd_req;
        dc_req    = bus.dc_rd_req | bus.dc_wr_req;
        ic_active = (state_q == OWN_IC) && ic_req;
        dc_active = (state_q == OWN_DC) && dc_req;
        dc_done   = dc_active && !bus.mem_wait;
        cnt_inc   = (starve_cnt_q == CNT_MAX) ? CNT_MAX : starve_cnt_q + CNT_W'(1);
        // A DC completion this cycle already counts, so IC gets in right after the limit-th DC grant
        cnt_eff   = (dc_done && ic_req) ? cnt_inc : starve_cnt_q;
        starved   = ic_req && (cnt_eff >= LIMIT);
        if (dc_req && !starved) begin
            arb = OWN_DC;
        end else if (ic_req) begin
            arb = OWN_IC;
        end else begin
            arb = IDLE;
        end
    end

    // State and starvation counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Next state: ownership moves only on a completion or when the owner has no request
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        unique case (state_q)
            IDLE: state_d = arb;
            OWN_IC: begin
                if (!ic_req) begin
                    state_d = arb;
                end else if (!bus.mem_wait && (arb == OWN_DC)) begin
                    state_d = OWN_DC;
                end
            end
            OWN_DC: begin
                if (!dc_req) begin
                    state_d = arb;
                end else if (!bus.mem_wait && (arb == OWN_IC)) begin
                    state_d = OWN_IC;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!ic_req || (state_d == OWN_IC)) begin
            starve_cnt_d = '0;
        end else begin
            starve_cnt_d = cnt_eff;
        end
    end

    assign bus.grant      = state_q;
    assign bus.ic_rd_data = bus.mem_rd_data;
    assign bus.dc_rd_data = bus.mem_rd_data;

    // Bus pass-through for the active owner; a requester not being served simply waits
    always_comb begin
        bus.mem_busaddr   = '0;
        bus.mem_wr_data   = '0;
        bus.mem_data_size = '0;
        bus.mem_rd_req    = 1'b0;
        bus.mem_wr_req    = 1'b0;
        bus.ic_rw_wait    = ic_req;
        bus.dc_rw_wait    = dc_req;
        if (!rst) begin
            if (ic_active) begin
                bus.mem_busaddr   = bus.ic_busaddr;
                bus.mem_data_size = SIZE_WORD;
                bus.mem_rd_req    = 1'b1;
                bus.ic_rw_wait    = bus.mem_wait;
            end else if (dc_active) begin
                bus.mem_busaddr   = bus.dc_busaddr;
                bus.mem_wr_data   = bus.dc_wr_data;
                bus.mem_data_size = bus.dc_data_size;
                bus.mem_rd_req    = bus.dc_rd_req;
                bus.mem_wr_req    = bus.dc_wr_req && !bus.dc_rd_req;
                bus.dc_rw_wait    = bus.mem_wait;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a per-cycle ownership model plus hand-computed checkpoints.
module tb_mem_bus_arbiter;

    localparam int LIMIT = 4;

    logic clk;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    bit   seen_reset = 0;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner 0 = nobody, 1 = IC, 2 = DC; streak = DC completions while IC has been waiting
    int m_owner  = 0;
    int m_streak = 0;
    int n_owner  = 0;
    int n_streak = 0;

    function automatic int pick(bit icr, bit dcr, int streak);
        if (dcr && !(icr && streak >= LIMIT)) return 2;
        if (icr) return 1;
        return 0;
    endfunction

    always @(negedge clk) begin
        bit icr, dcr, serving, done, exp_rd, exp_wr;
        int after;
        icr = bus.ic_rd_req;
        dcr = bus.dc_rd_req | bus.dc_wr_req;
        if (rst) begin
            if (seen_reset) begin
                chk("rst_mem_rd_req", 32'(bus.mem_rd_req), 32'd0);
                chk("rst_mem_wr_req", 32'(bus.mem_wr_req), 32'd0);
                chk("rst_ic_rw_wait", 32'(bus.ic_rw_wait), 32'(icr));
                chk("rst_dc_rw_wait", 32'(bus.dc_rw_wait), 32'(dcr));
            end
            n_owner  = 0;
            n_streak = 0;
        end else begin
            serving = (m_owner == 1 && icr) || (m_owner == 2 && dcr);
            done    = serving && !bus.mem_wait;
            after   = (m_owner == 2 && done && icr) ? ((m_streak >= 15) ? 15 : m_streak + 1) : m_streak;
            exp_rd  = serving && (m_owner == 1 || bus.dc_rd_req);
            exp_wr  = serving && m_owner == 2 && bus.dc_wr_req && !bus.dc_rd_req;
            if (seen_reset) begin
                chk("m_grant", 32'(bus.grant), 32'(m_owner));
                chk("m_starve_cnt", 32'(dut.starve_cnt_q), 32'(m_streak));
                chk("m_mem_rd_req", 32'(bus.mem_rd_req), 32'(exp_rd));
                chk("m_mem_wr_req", 32'(bus.mem_wr_req), 32'(exp_wr));
                chk("m_ic_rw_wait", 32'(bus.ic_rw_wait), 32'((m_owner == 1 && icr) ? bus.mem_wait : icr));
                chk("m_dc_rw_wait", 32'(bus.dc_rw_wait), 32'((m_owner == 2 && dcr) ? bus.mem_wait : dcr));
                chk("m_ic_rd_data", bus.ic_rd_data, bus.mem_rd_data);
                chk("m_dc_rd_data", bus.dc_rd_data, bus.mem_rd_data);
                if (serving) begin
                    chk("m_mem_busaddr", bus.mem_busaddr, (m_owner == 1) ? bus.ic_busaddr : bus.dc_busaddr);
                    chk("m_mem_size", 32'(bus.mem_data_size), 32'((m_owner == 1) ? 3'b100 : bus.dc_data_size));
                end
                if (exp_wr) chk("m_mem_wr_data", bus.mem_wr_data, bus.dc_wr_data);
            end
            if (!serving) n_owner = pick(icr, dcr, m_streak);
            else if (done && pick(icr, dcr, after) == 3 - m_owner) n_owner = 3 - m_owner;
            else n_owner = m_owner;
            n_streak = (!icr || n_owner == 1) ? 0 : after;
        end
    end

    always @(posedge clk) begin
        if (rst) seen_reset = 1;
        m_owner  = n_owner;
        m_streak = n_streak;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic neg;
        @(negedge clk);
    endtask

    logic [15:0] wait_pat;

    initial begin
        rst = 1'b1;
        bus.ic_busaddr = '0; bus.ic_rd_req = 0;
        bus.dc_busaddr = '0; bus.dc_rd_req = 0; bus.dc_wr_req = 0;
        bus.dc_wr_data = '0; bus.dc_data_size = 3'b100;
        bus.mem_wait = 0; bus.mem_rd_data = '0;
        tick; tick;
        rst = 1'b0;
        neg; chk("reset_grant", 32'(bus.grant), 32'd0);
        chk("reset_starve", 32'(dut.starve_cnt_q), 32'd0);
        chk("reset_mem_rd", 32'(bus.mem_rd_req), 32'd0);
        tick;

        // Single DC read with two wait cycles
        bus.dc_rd_req = 1; bus.dc_busaddr = 32'h100; bus.mem_wait = 1; bus.mem_rd_data = 32'hDEADBEEF;
        neg; chk("a_idle_wait", 32'(bus.dc_rw_wait), 32'd1); chk("a_idle_grant", 32'(bus.grant), 32'd0);
        chk("a_idle_no_req", 32'(bus.mem_rd_req), 32'd0);
        tick;
        neg; chk("a_grant", 32'(bus.grant), 32'd2); chk("a_rd_req", 32'(bus.mem_rd_req), 32'd1);
        chk("a_addr", bus.mem_busaddr, 32'h100); chk("a_wait1", 32'(bus.dc_rw_wait), 32'd1);
        tick;
        neg; chk("a_wait2", 32'(bus.dc_rw_wait), 32'd1);
        tick;
        bus.mem_wait = 0;
        neg; chk("a_done", 32'(bus.dc_rw_wait), 32'd0); chk("a_data", bus.dc_rd_data, 32'hDEADBEEF);
        tick;
        bus.dc_rd_req = 0;
        neg; chk("a_drop_rd", 32'(bus.mem_rd_req), 32'd0); chk("a_drop_grant", 32'(bus.grant), 32'd2);
        tick;

        // Simultaneous IC read and DC write, then IC back-to-back fetches
        bus.ic_rd_req = 1; bus.ic_busaddr = 32'h40;
        bus.dc_wr_req = 1; bus.dc_busaddr = 32'h200; bus.dc_wr_data = 32'h12345678; bus.dc_data_size = 3'b100;
        neg; chk("b_idle_grant", 32'(bus.grant), 32'd0); chk("b_idle_icw", 32'(bus.ic_rw_wait), 32'd1);
        tick;
        neg; chk("b_dc_grant", 32'(bus.grant), 32'd2); chk("b_wr_req", 32'(bus.mem_wr_req), 32'd1);
        chk("b_rd_req", 32'(bus.mem_rd_req), 32'd0); chk("b_wr_data", bus.mem_wr_data, 32'h12345678);
        chk("b_wr_addr", bus.mem_busaddr, 32'h200); chk("b_icw", 32'(bus.ic_rw_wait), 32'd1);
        tick;
        bus.dc_wr_req = 0;
        neg; chk("b_dc_tail_grant", 32'(bus.grant), 32'd2); chk("b_dc_tail_icw", 32'(bus.ic_rw_wait), 32'd1);
        tick;
        neg; chk("b_ic_grant", 32'(bus.grant), 32'd1); chk("b_ic_addr", bus.mem_busaddr, 32'h40);
        chk("b_ic_done", 32'(bus.ic_rw_wait), 32'd0);
        tick;
        for (int i = 1; i <= 2; i++) begin
            bus.ic_busaddr = 32'(i * 4);
            neg; chk("d_b2b_grant", 32'(bus.grant), 32'd1); chk("d_b2b_addr", bus.mem_busaddr, 32'(i * 4));
            chk("d_b2b_done", 32'(bus.ic_rw_wait), 32'd0);
            tick;
        end
        bus.ic_rd_req = 0;
        neg; chk("d_drop_rd", 32'(bus.mem_rd_req), 32'd0);
        tick;

        // Starvation guard: DC and IC both request continuously
        bus.ic_rd_req = 1; bus.ic_busaddr = 32'h80;
        bus.dc_rd_req = 1; bus.dc_busaddr = 32'h300; bus.dc_data_size = 3'b010; bus.mem_rd_data = 32'hCAFE0000;
        neg; chk("c_idle_grant", 32'(bus.grant), 32'd0);
        tick;
        for (int k = 0; k < LIMIT; k++) begin
            neg; chk("c_dc_run_grant", 32'(bus.grant), 32'd2); chk("c_dc_run_cnt", 32'(dut.starve_cnt_q), 32'(k));
            chk("c_dc_run_icw", 32'(bus.ic_rw_wait), 32'd1);
            tick;
        end
        neg; chk("c_ic_forced", 32'(bus.grant), 32'd1); chk("c_ic_cnt", 32'(dut.starve_cnt_q), 32'd0);
        chk("c_ic_done", 32'(bus.ic_rw_wait), 32'd0); chk("c_ic_addr", bus.mem_busaddr, 32'h80);
        tick;
        neg; chk("c_dc_resume", 32'(bus.grant), 32'd2);
        tick;
        repeat (8) tick;
        bus.ic_rd_req = 0; bus.dc_rd_req = 0;
        tick; tick;

        // Reset in the middle of a DC read
        bus.dc_rd_req = 1; bus.dc_busaddr = 32'h500; bus.dc_data_size = 3'b100; bus.mem_wait = 1;
        tick;
        neg; chk("r_grant", 32'(bus.grant), 32'd2); chk("r_rd_req", 32'(bus.mem_rd_req), 32'd1);
        tick;
        rst = 1;
        neg; chk("r_rst_rd", 32'(bus.mem_rd_req), 32'd0); chk("r_rst_dcw", 32'(bus.dc_rw_wait), 32'd1);
        tick;
        rst = 0;
        neg; chk("r_after_grant", 32'(bus.grant), 32'd0); chk("r_after_rd", 32'(bus.mem_rd_req), 32'd0);
        tick;
        bus.mem_wait = 0;
        neg; chk("r_regrant", 32'(bus.grant), 32'd2); chk("r_regrant_rd", 32'(bus.mem_rd_req), 32'd1);
        tick;
        bus.dc_rd_req = 0;
        tick; tick;

        // Read and write asserted together: read wins
        bus.dc_rd_req = 1; bus.dc_wr_req = 1; bus.dc_busaddr = 32'h600;
        tick;
        neg; chk("e_rd_wins", 32'(bus.mem_rd_req), 32'd1); chk("e_wr_supp", 32'(bus.mem_wr_req), 32'd0);
        tick;
        bus.dc_rd_req = 0; bus.dc_wr_req = 0;
        tick; tick;

        // Both busy with a fixed mem_wait pattern; only the model checks here
        wait_pat = 16'b0110_1001_1100_0101;
        bus.ic_rd_req = 1; bus.dc_wr_req = 1; bus.dc_wr_data = 32'hA5A5_0F0F;
        for (int i = 0; i < 16; i++) begin
            bus.mem_wait   = wait_pat[i];
            bus.ic_busaddr = 32'(i * 4);
            tick;
        end
        bus.ic_rd_req = 0; bus.dc_wr_req = 0; bus.mem_wait = 0;
        tick; tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
